// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the bit-serial adder
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int SA_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - combinational 1-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);

    // Sum and carry of a single bit position.
    always_comb begin
        sum = a ^ b ^ ci;
        co  = (a & b) | (a & ci) | (b & ci);
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller reusing one full_adder cell
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int N = SA_WIDTH
) (
    input  logic         clock,
    input  logic         n_reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    sa_state_t     state_q, state_d;
    logic [N-1:0]  a_sh_q;
    logic [N-1:0]  b_sh_q;
    logic [N-1:0]  sum_q;
    logic          carry_q;
    logic [CW-1:0] cnt_q;
    logic          fa_s;
    logic          fa_co;

    // The single shared adder cell always looks at the low bits of the shifters.
    full_adder u_fa (
        .a   (a_sh_q[0]),
        .b   (b_sh_q[0]),
        .ci  (carry_q),
        .sum (fa_s),
        .co  (fa_co)
    );

    // Next-state selection and status outputs decoded from the current state.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand shifters, partial sum, carry and bit counter.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    // Operands are captured only here; later input changes are ignored.
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        sum_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    // New result bit enters at the top so the LSB lands at bit 0 after N shifts.
                    carry_q <= fa_co;
                    sum_q   <= {fa_s, sum_q[N-1:1]};
                    a_sh_q  <= {1'b0, a_sh_q[N-1:1]};
                    b_sh_q  <= {1'b0, b_sh_q[N-1:1]};
                    cnt_q   <= cnt_q + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = carry_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: sequences one shared full_adder cell over N-bit operands, one bit per clock, LSB first.
- Trades N cycles of latency for a single adder cell.
- Sits between a requester (start/operand handshake) and the reused 1-bit full_adder datapath; reports completion with a one-cycle done pulse.

Parameters:
- N, 8, operand/result width in bits; legal range N >= 2.

Ports:
- clock  input  1  system clock, all state updates on rising edge
- n_reset  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when idle (busy=0)
- a  input  N  operand A, sampled on the accepted start cycle only
- b  input  N  operand B, sampled on the accepted start cycle only
- cin  input  1  carry-in, sampled on the accepted start cycle only
- busy  output  1  high from the cycle after acceptance until done clears
- done  output  1  single-cycle pulse, result valid
- sum  output  N  result register
- cout  output  1  carry register; final carry-out when done=1

Behaviour:
- One clock `clock`; reset `n_reset` is asynchronous, active-low; all flops clear immediately on n_reset=0, independent of clock.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, operand shift registers=0, bit counter=0.
- State machine states: IDLE, RUN, DONE.
  - IDLE: busy=0, done=0.
  - IDLE, start=1 at an edge: load a_sh<=a, b_sh<=b, carry<=cin, sum<=0, cnt<=0; next state RUN.
  - IDLE, start=0: remain IDLE; sum/cout hold their previous values.
  - RUN: busy=1, done=0. The full_adder sees a_sh[0], b_sh[0], carry.
  - RUN, each edge: carry<=co; sum<={s, sum[N-1:1]}; a_sh and b_sh shift right by one with zero fill; cnt<=cnt+1.
  - RUN, when cnt==N-1 at the edge: the last bit is processed and next state is DONE.
  - DONE: busy=1, done=1 for exactly one cycle; sum and cout hold. Next state IDLE unconditionally.
- cout is the carry register itself.
  - It changes during RUN.
  - It is architecturally valid only while done=1 and thereafter until the next accepted start.
- sum during RUN is a deterministic partial value (processed bits at the top, zeros below); consumers must use it only at or after done.
- Latency: start accepted at edge 0; RUN occupies edges 1..N; done=1 in the cycle after edge N. The result appears N+1 cycles after acceptance; throughput is one add per N+2 cycles.
- start while busy=1 (RUN or DONE) is ignored: no operand resample, no queueing.
- Back-to-back: start held high through DONE is accepted in the following IDLE cycle.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(N+1); no overflow flag.
- cnt width is $clog2(N); no wrap occurs because the exit condition is cnt==N-1.
- Reset mid-RUN or in DONE: abort immediately to reset values; no done pulse is produced for the aborted operation.
- Operand inputs a/b/cin may change freely after acceptance without affecting the result.

Decomposition:
- Shared package serial_add_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t.
  - Default width constant SA_WIDTH = 8.
- Sub-module: one instance of the existing full_adder (ports sum, co, a, b, ci), purely combinational, driven by a_sh[0], b_sh[0], carry.
- The controller holds the FSM, counter, shift registers and carry flop in a single always_ff plus an always_comb for next-state and outputs.

Test Plan:
- N=8, a=8'h3C, b=8'h05, cin=0, pulse start -> busy=1 for cycles 1..9, done pulse in cycle 9, sum=8'h41, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. a=8'h7F, b=8'h80, cin=1 -> sum=8'h00, cout=1. a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0.
- Accept a=8'h10, b=8'h20; in cycle 3 pulse start with a=8'hFF, b=8'hFF and change inputs -> second request ignored; done gives sum=8'h30, cout=0, single done pulse.
- Hold start=1 continuously with a=8'h01, b=8'h01 -> done pulses every 10 cycles (N+2), each time sum=8'h02; busy low exactly one cycle between operations.
- Assert n_reset=0 asynchronously mid-RUN (cycle 4, between edges) -> busy, done, sum, cout go 0 without a clock edge; after release, no spurious done; a new start with a=8'h0A, b=8'h05 gives sum=8'h0F.
- Randomized sweep, 1000 operations, N=8 and N=16 -> {cout,sum} == a+b+cin at every done; done never asserted outside DONE.
